// File: rtl/led_fader_pkg.sv
// Shared defaults and helper arithmetic for the LED comet-trail fader.
// Gamma curve is compiled in only when LED_FADER_GAMMA_EN is defined.
package led_fader_pkg;

  localparam int LED_FADER_N_LEDS     = 10;
  localparam int LED_FADER_BW         = 8;
  localparam int LED_FADER_DECAY_DIV  = 250000;
  localparam int LED_FADER_DECAY_STEP = 16;

  // Saturating decrement: a level never wraps below zero.
  function automatic logic [31:0] sat_sub(input logic [31:0] level,
                                          input logic [31:0] step);
    return (level > step) ? (level - step) : 32'd0;
  endfunction

  // Square-law brightness; full scale is kept exact so a lit LED is solid on.
  function automatic logic [31:0] gamma(input logic [31:0] level,
                                        input int unsigned bw);
    logic [31:0] lmax;
    logic [63:0] sq;
    lmax = (32'd1 << bw) - 32'd1;
    sq   = {32'd0, level} * {32'd0, level};
    if (level == lmax) return lmax;
    return 32'(sq >> bw);
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level with tick-driven decay and PWM compare.
// LED_FADER_GAMMA_EN selects the square-law brightness curve.
module led_fade_channel
  import led_fader_pkg::*;
#(
  parameter int BW         = LED_FADER_BW,
  parameter int DECAY_STEP = LED_FADER_DECAY_STEP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pat,
  input  logic          tick,
  input  logic [BW-1:0] pwm_cnt,
  output logic          on
);

  localparam logic [BW-1:0] LMAX = {BW{1'b1}};

  logic [BW-1:0] level_p1;
  logic [BW-1:0] eff;

  // Stage p1: level register; a lit pattern bit beats a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_p1 <= '0;
    end else if (pat) begin
      level_p1 <= LMAX;
    end else if (tick) begin
      level_p1 <= BW'(sat_sub(32'(level_p1), 32'(DECAY_STEP)));
    end
  end

  always_comb begin
    eff = level_p1;
`ifdef LED_FADER_GAMMA_EN
    eff = BW'(gamma(32'(level_p1), BW));
`endif
  end

  assign on = (pwm_cnt < eff);

endmodule

// File: rtl/led_trail_fader.sv
// Comet-trail fader between the scanner pattern and the board LEDs.
// Optional square-law fade via LED_FADER_GAMMA_EN (see led_fade_channel).
module led_trail_fader
  import led_fader_pkg::*;
#(
  parameter int N_LEDS     = LED_FADER_N_LEDS,
  parameter int BW         = LED_FADER_BW,
  parameter int DECAY_DIV  = LED_FADER_DECAY_DIV,
  parameter int DECAY_STEP = LED_FADER_DECAY_STEP
) (
  input  logic              CLOCK_50,
  input  logic              RESETn,
  input  logic [N_LEDS-1:0] PAT_IN,
  input  logic              ENABLE,
  output logic [N_LEDS-1:0] LED,
  output logic              DECAY_TICK
);

  localparam int               DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);
  localparam logic [BW-1:0]    PWM_LAST = BW'((1 << BW) - 2);

  logic [N_LEDS-1:0] pat_p0;
  logic [N_LEDS-1:0] on_p1;
  logic [DIV_W-1:0]  div_cnt;
  logic [BW-1:0]     pwm_cnt;
  logic              tick;

  assign tick = (div_cnt == DIV_LAST);

  // Stage p0: input register, shared decay divider and PWM ramp; p2: LED drive.
  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      pat_p0     <= '0;
      div_cnt    <= '0;
      pwm_cnt    <= '0;
      DECAY_TICK <= 1'b0;
      LED        <= '0;
    end else begin
      pat_p0     <= PAT_IN;
      div_cnt    <= tick ? '0 : div_cnt + DIV_W'(1);
      pwm_cnt    <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + BW'(1);
      DECAY_TICK <= tick;
      LED        <= ENABLE ? on_p1 : pat_p0;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_fade_channel #(
      .BW        (BW),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk    (CLOCK_50),
      .rst_n  (RESETn),
      .pat    (pat_p0[i]),
      .tick   (tick),
      .pwm_cnt(pwm_cnt),
      .on     (on_p1[i])
    );
  end

endmodule

// File: tb/tb_led_trail_fader.sv
// Self-checking bench for led_trail_fader: cycle-level reference model plus
// hand-computed duty/latency expectations. Honors LED_FADER_GAMMA_EN.
module tb_led_trail_fader;

  localparam int N    = 10;
  localparam int BW   = 8;
  localparam int DIV  = 1016;
  localparam int STEP = 64;
  localparam int LMAX = 255;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b1;
  logic [N-1:0] pat   = '0;
  logic [N-1:0] led;
  logic         dtick;

  led_trail_fader #(
    .N_LEDS(N), .BW(BW), .DECAY_DIV(DIV), .DECAY_STEP(STEP)
  ) dut (
    .CLOCK_50  (clk),
    .RESETn    (rst_n),
    .PAT_IN    (pat),
    .ENABLE    (en),
    .LED       (led),
    .DECAY_TICK(dtick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: time since reset gives divider and PWM phase directly.
  int           m_level[N];
  logic [N-1:0] m_patq;
  logic [N-1:0] m_led;
  logic         m_tick;
  int           n;

  function automatic int m_eff(input int lv);
`ifdef LED_FADER_GAMMA_EN
    return (lv == LMAX) ? LMAX : (lv * lv) / 256;
`else
    return lv;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_level[i] = 0;
      m_patq = '0;
      m_led  = '0;
      m_tick = 1'b0;
      n      = 0;
    end else begin
      int pwm;
      bit tk;
      pwm = n % LMAX;
      tk  = ((n % DIV) == DIV - 1);
      for (int i = 0; i < N; i++)
        m_led[i] = en ? (pwm < m_eff(m_level[i])) : m_patq[i];
      for (int i = 0; i < N; i++) begin
        if (m_patq[i])  m_level[i] = LMAX;
        else if (tk)    m_level[i] = (m_level[i] > STEP) ? m_level[i] - STEP : 0;
      end
      m_tick = tk;
      m_patq = pat;
      n++;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("led_model", int'(led), int'(m_led));
      chk("tick_model", int'(dtick), int'(m_tick));
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      if (dtick) begin ok = 1'b1; break; end
    end
    if (!ok) chk("tick_timeout", 0, 1);
  endtask

  task automatic window(input int ch, output int hi);
    hi = 0;
    repeat (255) begin
      @(negedge clk);
      hi += int'(led[ch]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, hi, errs;
    int exp_dec[5];
    int exp_127;
    logic [N-1:0] hist[$];
`ifdef LED_FADER_GAMMA_EN
    exp_dec = '{142, 63, 15, 0, 0};
    exp_127 = 63;
`else
    exp_dec = '{191, 127, 63, 0, 0};
    exp_127 = 127;
`endif
    cyc(3);
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Reset mid-fade clears outputs immediately, then divider restarts at 0
    pat = 10'h3FF;
    cyc(100);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_led", int'(led), 0);
    chk("rst_tick", int'(dtick), 0);
    cyc(2);
    pat   = '0;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      cnt++;
      if (dtick) break;
    end
    chk("first_tick", cnt, DIV);

    // Hold: LED[3] appears on the third edge and stays solid
    pat = 10'h008;
    cyc(2);
    chk("hold_lat_k1", int'(led[3]), 0);
    cyc(1);
    chk("hold_lat_k2", int'(led[3]), 1);
    errs = 0;
    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      hi += int'(led[3]);
      if (led != 10'h008) errs++;
    end
    chk("hold_on", hi, 1000);
    chk("hold_others", errs, 0);

    // Linear decay duty per window after each tick, then no wrap
    wait_tick();
    pat = '0;
    for (int j = 0; j < 5; j++) begin
      wait_tick();
      window(3, hi);
      chk($sformatf("decay_win%0d", j), hi, exp_dec[j]);
    end

    // Pattern held across a tick keeps the LED solid
    pat = 10'h020;
    cyc(3);
    hi = 0;
    repeat (1400) begin
      @(negedge clk);
      hi += int'(led[5]);
    end
    chk("simul_solid", hi, 1400);
    pat = '0;
    cyc(3);

    // Bypass walking one: LED mirrors the pattern two cycles later
    en = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j >= 2) chk("bypass", int'(led), int'(hist[j-2]));
      pat = 10'(1 << (j % N));
      hist.push_back(pat);
    end
    @(negedge clk);
    pat = '0;
    cyc(3);
    wait_tick();
    wait_tick();
    en = 1'b1;
    window(9, hi);
    chk("reenable_duty", hi, exp_127);

    // Random sparse patterns, enable toggles and one asynchronous reset
    for (int j = 0; j < 4000; j++) begin
      @(negedge clk);
      pat = ($urandom_range(0, 15) == 0) ? 10'(1 << $urandom_range(0, N - 1)) : '0;
      if ($urandom_range(0, 299) == 0) en = ~en;
      if (j == 2500) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rand_rst_led", int'(led), 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    cyc(2);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_trail_fader.md
# led_trail_fader

Downstream stage of the Knight Rider scanner: consumes the scanner's raw 10-bit one-hot LED pattern and drives the board LEDs with a fading "comet trail". Every LED that switches off decays in brightness through per-LED PWM instead of going dark at once. The block sits between the scanner's pattern output and the `LED` pins in the board top level.

## Interface
- `N_LEDS`, 10: number of LED channels.
- `BW`, 8: brightness width; `LMAX` = 2^BW-1.
- `DECAY_DIV`, 250000: clock cycles per decay tick (5 ms at 50 MHz); must be ≥ 1.
- `DECAY_STEP`, 16: brightness subtracted per decay tick; 1..LMAX.
- `CLOCK_50`  in  1: the single clock; all state is on the rising edge.
- `RESETn`  in  1: asynchronous, active-low reset.
- `PAT_IN`  in  N_LEDS: raw scanner pattern, synchronous to `CLOCK_50`.
- `ENABLE`  in  1: 1 = fading output; 0 = bypass (LEDs follow the pattern).
- `LED`  out  N_LEDS: LED drive, registered.
- `DECAY_TICK`  out  1: one-cycle strobe on each decay tick, for debug and bench.

## Operation
- **Input stage.** `pat_q` <= `PAT_IN` every cycle.
- **Decay divider.** `div_cnt` counts 0..DECAY_DIV-1 and wraps to 0. `tick` is 1 in the cycle where `div_cnt` = DECAY_DIV-1.
- **Per-channel level** `level[i]` (BW bits):
  - If `pat_q[i]`=1: `level` <= LMAX. The pattern wins over a simultaneous tick.
  - Else if `tick`: `level` <= (`level` > DECAY_STEP) ? `level`-DECAY_STEP : 0. Saturates at 0 and never wraps.
  - Else: hold.
- **PWM.** `pwm_cnt` (BW bits) counts 0..LMAX-1 and wraps to 0, so the period is LMAX cycles.
- **Output compare.** `on[i]` = (`pwm_cnt` < `eff[i]`).
  - `eff` = LMAX gives constant on.
  - `eff` = 0 gives constant off.
  - Duty = `eff`/LMAX.
- **Output register.**
  - `ENABLE`=1: `LED[i]` <= `on[i]`.
  - `ENABLE`=0: `LED[i]` <= `pat_q[i]`.
- **During bypass.** Levels, divider and PWM keep running. Re-enabling takes effect on the next cycle with no glitch beyond normal PWM phase.
- **Reset.** All registers clear to 0: `pat_q`, `div_cnt`, `pwm_cnt`, every `level`, `LED`, `DECAY_TICK`. `RESETn` asserted mid-fade clears LEDs immediately (asynchronous). After release, operation restarts with the divider and PWM at 0.

## Timing
- **Fade path latency.** `PAT_IN` change sampled at edge k → `pat_q` at k → `level` at k+1 → `LED` at k+2. Three edges from sampling to output.
- **Bypass path latency.** `PAT_IN` at edge k → `LED` at edge k+1.
- **`DECAY_TICK`.** Registered copy of `tick`. First assertion is DECAY_DIV cycles after reset release, then every DECAY_DIV cycles.
- **Full fade time.** ceil(LMAX/DECAY_STEP) ticks, measured from the tick after `pat_q[i]` falls.
- **`ENABLE` change.** Affects `LED` at the next edge.

## Configuration
- **`LED_FADER_GAMMA_EN` defined:**
  - `eff` = (`level`==LMAX) ? LMAX : (`level`*`level`)>>BW.
  - The multiply is 2·BW bits wide, unsigned, and truncated after the shift.
  - This gives perceptually linear fading.
- **Not defined:** `eff` = `level`. Linear, no multiplier.

## Structure
- **Package `led_fader_pkg`:**
  - default constants (`LED_FADER_N_LEDS`, `LED_FADER_BW`, `LED_FADER_DECAY_DIV`, `LED_FADER_DECAY_STEP`);
  - function `sat_sub(level, step)`;
  - function `gamma(level)`.
- **Sub-module `led_fade_channel`:**
  - one per LED, instantiated by generate;
  - holds `level`, computes `eff` and `on`;
  - shared `tick` and `pwm_cnt` come from the top of the block.
- The top of the block holds the divider, PWM counter, input register and output mux/register.

## Test plan
- **Reset.** Drive `PAT_IN`=10'h3FF for 100 cycles, then pull `RESETn` low between edges → `LED`=0 and all levels 0 immediately. After release, `DECAY_TICK` first pulses exactly DECAY_DIV cycles later.
- **Hold.** With BW=8, `PAT_IN`=10'h008 held → `LED[3]` goes high at edge k+2 and stays 1 for 1000 cycles; all other LEDs stay 0.
- **Linear decay** (DECAY_DIV=1016, DECAY_STEP=64, macro off). Pulse `PAT_IN[3]` then hold it at 0:
  - `level[3]` follows 255→191→127→63→0 on successive ticks;
  - measured duty per 255-cycle window is 191, 127, 63, 0 high cycles;
  - the level stays 0 afterwards with no wrap.
- **Simultaneous events.** Assert `PAT_IN[5]` in the same cycle `tick`=1 with `level[5]`=255 → level remains 255 and `LED[5]` stays constantly high.
- **Bypass.** `ENABLE`=0 with a walking-one pattern → `LED` equals `PAT_IN` delayed 2 cycles. Toggle `ENABLE` to 1 mid-fade → the PWM trail resumes from the current level (e.g. 127 → 127/255 duty).
- **Gamma** (`LED_FADER_GAMMA_EN` defined). Force `level`=127 → 63 high cycles per 255-cycle window; `level`=255 → 255 high cycles. Without the macro, `level`=127 gives 127.
